// File: rtl/fb_arbiter.sv
// Frame buffer arbiter: one single-port memory shared by a VGA reader (absolute
// priority) and a camera writer queued through a small write FIFO.
module fb_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int MEM_LAT    = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rd_req,
   input  logic [ADDR_W-1:0]               rd_addr,
   output logic [DATA_W-1:0]               rd_data,
   output logic                            rd_valid,
   input  logic                            wr_req,
   input  logic [ADDR_W-1:0]               wr_addr,
   input  logic [DATA_W-1:0]               wr_data,
   output logic                            wr_full,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   input  logic                            ovf_clr,
   output logic                            mem_en,
   output logic                            mem_we,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   input  logic [DATA_W-1:0]               mem_rdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR
   } state_t;

   state_t state;
   state_t next_state;

   logic              rd_req_q;
   logic [ADDR_W-1:0] rd_addr_q;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic              push;
   logic              pop;
   logic              drop;

   logic [MEM_LAT:0]  valid_pipe;

   assign wr_full    = (count == LVL_W'(FIFO_DEPTH));
   assign fifo_level = count;
   assign push       = wr_req && !wr_full;
   assign drop       = wr_req && wr_full;
   assign pop        = (next_state == WR);

   // Grant decision uses the registered read request, so a queued write can
   // only win when no read was seen on the previous cycle.
   always_comb begin
      next_state = IDLE;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      if (rd_req_q) begin
         next_state = RD;
      end else if (count != '0) begin
         next_state = WR;
      end
      if (state != IDLE) begin
         mem_en = 1'b1;
      end
      if (state == WR) begin
         mem_we = 1'b1;
      end
   end

   // Memory address/data are loaded on the edge that enters RD or WR and
   // simply hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= next_state;
         rd_req_q  <= rd_req;
         rd_addr_q <= rd_addr;
         if (next_state == RD) begin
            mem_addr <= rd_addr_q;
         end else if (next_state == WR) begin
            mem_addr  <= fifo_addr[rd_ptr];
            mem_wdata <= fifo_data[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         // A drop wins over a simultaneous clear so no lost word goes unreported.
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_addr[wr_ptr] <= wr_addr;
         fifo_data[wr_ptr] <= wr_data;
      end
   end

   // One valid bit per issued read, aligned so the last stage coincides with
   // mem_rdata being valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_pipe <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         valid_pipe[0] <= (next_state == RD);
         for (int i = 1; i <= MEM_LAT; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
         end
         rd_valid <= valid_pipe[MEM_LAT];
         if (valid_pipe[MEM_LAT]) begin
            rd_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a one-cycle-latency memory model and
// logs of every memory write and returned pixel.
module tb_fb_arbiter;

   localparam int ADDR_W     = 19;
   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 8;
   localparam int MEM_LAT    = 1;
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_full;
   logic [LVL_W-1:0]  fifo_level;
   logic              overflow;
   logic              ovf_clr = 1'b0;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int rd_cycles = 0;

   logic [ADDR_W-1:0] wr_log_addr [$];
   logic [DATA_W-1:0] wr_log_data [$];
   int                wr_log_cyc  [$];
   logic [DATA_W-1:0] rd_log      [$];
   int                rd_log_cyc  [$];

   fb_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .wr_req(wr_req),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_full(wr_full),
      .fifo_level(fifo_level),
      .overflow(overflow),
      .ovf_clr(ovf_clr),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
      return a[DATA_W-1:0] + 12'h999;
   endfunction

   // Memory model and observers: sampled on the rising edge, before the DUT updates.
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (mem_en && !mem_we) begin
         mem_rdata <= memWord(mem_addr);
         rd_cycles <= rd_cycles + 1;
      end
      if (mem_en && mem_we) begin
         wr_log_addr.push_back(mem_addr);
         wr_log_data.push_back(mem_wdata);
         wr_log_cyc.push_back(cycle);
      end
      if (rd_valid) begin
         rd_log.push_back(rd_data);
         rd_log_cyc.push_back(cycle);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic [ADDR_W-1:0] raddr,
                                input logic wr, input logic [ADDR_W-1:0] waddr,
                                input logic [DATA_W-1:0] wdata);
      rd_req  = rd;
      rd_addr = raddr;
      wr_req  = wr;
      wr_addr = waddr;
      wr_data = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, 1'b0, '0, '0);
      end
   endtask

   task automatic checkWrites(input string tag, input int base, input int n,
                              input logic [ADDR_W-1:0] addr0, input logic [DATA_W-1:0] data0);
      int avail;
      checkOutput({tag, "_count"}, 32'(wr_log_addr.size() - base), 32'(n));
      avail = wr_log_addr.size() - base;
      if (avail > n) avail = n;
      for (int k = 0; k < avail; k++) begin
         checkOutput({tag, "_addr"}, 32'(wr_log_addr[base+k]), 32'(addr0 + ADDR_W'(k)));
         checkOutput({tag, "_data"}, 32'(wr_log_data[base+k]), 32'(data0 + DATA_W'(k)));
      end
   endtask

   initial begin
      int wb;
      int rb;
      int rc;

      // Reset state
      rst = 1'b1;
      idleCycles(2);
      rst = 1'b0;
      checkOutput("rst_mem_en", 32'(mem_en), 0);
      checkOutput("rst_mem_we", 32'(mem_we), 0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 0);
      checkOutput("rst_rd_valid", 32'(rd_valid), 0);
      checkOutput("rst_rd_data", 32'(rd_data), 0);
      checkOutput("rst_level", 32'(fifo_level), 0);
      checkOutput("rst_wr_full", 32'(wr_full), 0);
      checkOutput("rst_overflow", 32'(overflow), 0);

      // Single read: sampled at T, issued at T+1, returned at T+3
      applyStimulus(1'b1, 19'h00123, 1'b0, '0, '0);
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      checkOutput("rd_mem_en", 32'(mem_en), 1);
      checkOutput("rd_mem_we", 32'(mem_we), 0);
      checkOutput("rd_mem_addr", 32'(mem_addr), 32'h00123);
      idleCycles(1);
      checkOutput("rd_valid_early", 32'(rd_valid), 0);
      idleCycles(1);
      checkOutput("rd_valid", 32'(rd_valid), 1);
      checkOutput("rd_data", 32'(rd_data), 32'hABC);
      idleCycles(1);
      checkOutput("rd_valid_once", 32'(rd_valid), 0);

      // Write only
      wb = wr_log_addr.size();
      applyStimulus(1'b0, '0, 1'b1, 19'h00010, 12'h5A5);
      checkOutput("wo_level1", 32'(fifo_level), 1);
      checkOutput("wo_no_bypass", 32'(mem_en), 0);
      idleCycles(1);
      checkOutput("wo_mem_en", 32'(mem_en), 1);
      checkOutput("wo_mem_we", 32'(mem_we), 1);
      checkOutput("wo_mem_addr", 32'(mem_addr), 32'h00010);
      checkOutput("wo_mem_wdata", 32'(mem_wdata), 32'h5A5);
      checkOutput("wo_level0", 32'(fifo_level), 0);
      idleCycles(1);
      checkOutput("idle_mem_en", 32'(mem_en), 0);
      checkOutput("idle_hold_addr", 32'(mem_addr), 32'h00010);
      checkOutput("idle_hold_wdata", 32'(mem_wdata), 32'h5A5);
      idleCycles(3);

      // Contention: 4 pushes under a 10-cycle read burst
      wb = wr_log_addr.size();
      rb = rd_log.size();
      rc = rd_cycles;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, ADDR_W'(32'h80 + i), (i < 4), ADDR_W'(32'h100 + i), DATA_W'(32'h300 + i));
      end
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      checkOutput("ct_level_held", 32'(fifo_level), 4);
      checkOutput("ct_no_writes", 32'(wr_log_addr.size() - wb), 0);
      idleCycles(8);
      checkOutput("ct_rd_cycles", 32'(rd_cycles - rc), 10);
      checkWrites("ct_wr", wb, 4, 19'h00100, 12'h300);
      if (wr_log_cyc.size() >= wb + 4)
         checkOutput("ct_wr_consecutive", 32'(wr_log_cyc[wb+3] - wr_log_cyc[wb]), 3);
      checkOutput("ct_rd_count", 32'(rd_log.size() - rb), 10);
      if (rd_log.size() >= rb + 10) begin
         checkOutput("ct_rd_b2b", 32'(rd_log_cyc[rb+9] - rd_log_cyc[rb]), 9);
         for (int k = 0; k < 10; k++)
            checkOutput("ct_rd_order", 32'(rd_log[rb+k]), 32'(memWord(ADDR_W'(32'h80 + k))));
      end
      checkOutput("ct_level_drained", 32'(fifo_level), 0);

      // Overflow with reads held
      wb = wr_log_addr.size();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, '0, 1'b1, ADDR_W'(32'h200 + i), DATA_W'(32'h400 + i));
      end
      checkOutput("ov_full", 32'(wr_full), 1);
      checkOutput("ov_level8", 32'(fifo_level), 8);
      checkOutput("ov_not_yet", 32'(overflow), 0);
      applyStimulus(1'b1, '0, 1'b1, 19'h00208, 12'h408);
      checkOutput("ov_set", 32'(overflow), 1);
      checkOutput("ov_level_kept", 32'(fifo_level), 8);
      ovf_clr = 1'b1;
      applyStimulus(1'b1, '0, 1'b1, 19'h002FF, 12'hFFF);
      ovf_clr = 1'b0;
      checkOutput("ov_drop_beats_clr", 32'(overflow), 1);
      ovf_clr = 1'b1;
      applyStimulus(1'b1, '0, 1'b0, '0, '0);
      ovf_clr = 1'b0;
      checkOutput("ov_cleared", 32'(overflow), 0);
      checkOutput("ov_no_writes", 32'(wr_log_addr.size() - wb), 0);
      idleCycles(14);
      checkWrites("ov_wr", wb, 8, 19'h00200, 12'h400);
      checkOutput("ov_level0", 32'(fifo_level), 0);
      checkOutput("ov_full_clear", 32'(wr_full), 0);

      // Simultaneous push and pop at level 3
      wb = wr_log_addr.size();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, '0, 1'b1, ADDR_W'(32'h280 + i), DATA_W'(32'h500 + i));
      end
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      checkOutput("pp_level3", 32'(fifo_level), 3);
      applyStimulus(1'b0, '0, 1'b1, 19'h00283, 12'h503);
      checkOutput("pp_level_same", 32'(fifo_level), 3);
      checkOutput("pp_mem_we", 32'(mem_we), 1);
      idleCycles(8);
      checkWrites("pp_wr", wb, 4, 19'h00280, 12'h500);

      // Pointer wrap: 20 pushes with intermittent reads
      wb = wr_log_addr.size();
      for (int i = 0; i < 20; i++) begin
         applyStimulus((i % 4 == 0), '0, 1'b1, ADDR_W'(32'h300 + i), DATA_W'(32'h600 + i));
      end
      idleCycles(15);
      checkWrites("wrap_wr", wb, 20, 19'h00300, 12'h600);
      checkOutput("wrap_level0", 32'(fifo_level), 0);
      checkOutput("wrap_no_ovf", 32'(overflow), 0);

      // Reset mid-read with a queued write
      wb = wr_log_addr.size();
      rb = rd_log.size();
      applyStimulus(1'b1, 19'h00055, 1'b1, 19'h003AA, 12'h777);
      rst = 1'b1;
      applyStimulus(1'b1, 19'h00066, 1'b1, 19'h003BB, 12'h778);
      rst = 1'b0;
      checkOutput("mr_level0", 32'(fifo_level), 0);
      checkOutput("mr_overflow", 32'(overflow), 0);
      checkOutput("mr_mem_en", 32'(mem_en), 0);
      checkOutput("mr_rd_valid", 32'(rd_valid), 0);
      idleCycles(5);
      checkOutput("mr_no_rd_valid", 32'(rd_log.size() - rb), 0);
      checkOutput("mr_no_writes", 32'(wr_log_addr.size() - wb), 0);
      checkOutput("mr_level_end", 32'(fifo_level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
